// File: rtl/panel_ctrl_pkg.sv
// panel_ctrl_pkg: shared request indices and timing constants for the front-panel controller
package panel_ctrl_pkg;
   localparam int NUM_BTN        = 3;
   localparam int REQ_RUN        = 0;
   localparam int REQ_PHASE      = 1;
   localparam int REQ_INST       = 2;
   localparam int LOCKOUT_CYCLES = 2;
   localparam int LOCK_W         = $clog2(LOCKOUT_CYCLES + 1);
   typedef logic [NUM_BTN-1:0] btn_vec_t;
endpackage

// File: rtl/panel_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stable-count debounce and registered press-edge pulse
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic btn,
   output logic level,
   output logic press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          db_q, db_d, press_q, press_d, diff, done;
   always_comb begin
      sync_d  = {sync_q[0], btn ^ BTN_ACTIVE_LOW};
      diff    = sync_q[1] != db_q;
      done    = diff && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
      cnt_d   = (!diff || done) ? '0 : cnt_q + CW'(1);
      db_d    = done ? sync_q[1] : db_q;
      press_d = db_d & ~db_q;
   end
   always_ff @(posedge clock) begin
      if (!reset) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         db_q    <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         db_q    <= db_d;
         press_q <= press_d;
      end
   end
   assign level = db_q;
   assign press = press_q;
endmodule

// File: rtl/panel_ctrl.sv
// panel_ctrl: front-panel request generator for the phase generator (run / step_phase / step_inst)
module panel_ctrl
   import panel_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_run,
   input  logic       btn_step_phase,
   input  logic       btn_step_inst,
   input  logic       running,
   input  logic       halt,
   output logic       run,
   output logic       step_phase,
   output logic       step_inst,
   output logic [2:0] btn_level
);
   btn_vec_t          raw, level, press, req_d, req_q;
   logic [LOCK_W-1:0] lock_q, lock_d;
   logic              halt_done_q, halt_done_d, halt_stop, idle, step_ok;
   assign raw[REQ_RUN]   = btn_run;
   assign raw[REQ_PHASE] = btn_step_phase;
   assign raw[REQ_INST]  = btn_step_inst;
   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
      ) u_db (
         .clock(clock),
         .reset(reset),
         .btn  (raw[i]),
         .level(level[i]),
         .press(press[i])
      );
   end
   // Fixed priority: halt stop, run press, step_inst, step_phase; losers are dropped.
   always_comb begin
      idle                = lock_q == '0;
      halt_stop           = running & halt & ~halt_done_q;
      step_ok             = idle & ~halt_stop & ~press[REQ_RUN] & ~running;
      req_d               = '0;
      req_d[REQ_RUN]      = idle & (halt_stop | press[REQ_RUN]);
      req_d[REQ_INST]     = step_ok & press[REQ_INST];
      req_d[REQ_PHASE]    = step_ok & ~press[REQ_INST] & press[REQ_PHASE];
      halt_done_d         = halt & (halt_done_q | (idle & halt_stop));
      lock_d              = (|req_d) ? LOCK_W'(LOCKOUT_CYCLES) : (idle ? '0 : lock_q - LOCK_W'(1));
   end
   always_ff @(posedge clock) begin
      if (!reset) begin
         req_q       <= '0;
         lock_q      <= '0;
         halt_done_q <= 1'b0;
      end else begin
         req_q       <= req_d;
         lock_q      <= lock_d;
         halt_done_q <= halt_done_d;
      end
   end
   assign run        = req_q[REQ_RUN];
   assign step_phase = req_q[REQ_PHASE];
   assign step_inst  = req_q[REQ_INST];
   assign btn_level  = level;
endmodule

// File: tb/tb_panel_ctrl.sv
// tb_panel_ctrl: table-driven directed bench for panel_ctrl with DEBOUNCE_CYCLES=4
module tb_panel_ctrl;
   logic       clock = 1'b0;
   logic       reset, btn_run, btn_step_phase, btn_step_inst, running, halt;
   logic       run, step_phase, step_inst;
   logic [2:0] btn_level;
   int         applied = 0;
   int         errors  = 0;

   always #5 clock = ~clock;

   panel_ctrl #(.DEBOUNCE_CYCLES(4), .BTN_ACTIVE_LOW(1'b0)) dut (
      .clock(clock), .reset(reset), .btn_run(btn_run), .btn_step_phase(btn_step_phase),
      .btn_step_inst(btn_step_inst), .running(running), .halt(halt), .run(run),
      .step_phase(step_phase), .step_inst(step_inst), .btn_level(btn_level)
   );

   // btn and req are {inst, phase, run}; each record is held for n cycles
   typedef struct {
      int         n;
      logic       rst_n;
      logic [2:0] btn;
      logic       running;
      logic       halt;
      logic [2:0] req;
      logic [2:0] lvl;
   } vec_t;

   vec_t v[$];

   function automatic vec_t mk(int n, logic r, logic [2:0] b, logic ru, logic h, logic [2:0] q, logic [2:0] l);
      vec_t x;
      x.n = n; x.rst_n = r; x.btn = b; x.running = ru; x.halt = h; x.req = q; x.lvl = l;
      return x;
   endfunction

   initial begin
      int pulses, first, others;
      reset = 1'b0; btn_run = 1'b0; btn_step_phase = 1'b0; btn_step_inst = 1'b0;
      running = 1'b0; halt = 1'b0;
      // reset and idle
      v.push_back(mk(3, 0, 3'b000, 0, 0, 3'b000, 3'b000));
      v.push_back(mk(3, 1, 3'b000, 0, 0, 3'b000, 3'b000));
      // step_inst held: level at +6, single pulse at +7, release silent
      v.push_back(mk(5, 1, 3'b100, 0, 0, 3'b000, 3'b000));
      v.push_back(mk(1, 1, 3'b100, 0, 0, 3'b000, 3'b100));
      v.push_back(mk(1, 1, 3'b100, 0, 0, 3'b100, 3'b100));
      v.push_back(mk(6, 1, 3'b100, 0, 0, 3'b000, 3'b100));
      v.push_back(mk(5, 1, 3'b000, 0, 0, 3'b000, 3'b100));
      v.push_back(mk(4, 1, 3'b000, 0, 0, 3'b000, 3'b000));
      // 3-cycle glitch and 3-cycle bounce on run: nothing
      v.push_back(mk(3, 1, 3'b001, 0, 0, 3'b000, 3'b000));
      v.push_back(mk(3, 1, 3'b000, 0, 0, 3'b000, 3'b000));
      v.push_back(mk(3, 1, 3'b001, 0, 0, 3'b000, 3'b000));
      v.push_back(mk(8, 1, 3'b000, 0, 0, 3'b000, 3'b000));
      // 4-cycle run press is just long enough
      v.push_back(mk(4, 1, 3'b001, 0, 0, 3'b000, 3'b000));
      v.push_back(mk(1, 1, 3'b000, 0, 0, 3'b000, 3'b000));
      v.push_back(mk(1, 1, 3'b000, 0, 0, 3'b000, 3'b001));
      v.push_back(mk(1, 1, 3'b000, 0, 0, 3'b001, 3'b001));
      v.push_back(mk(2, 1, 3'b000, 0, 0, 3'b000, 3'b001));
      v.push_back(mk(4, 1, 3'b000, 0, 0, 3'b000, 3'b000));
      // run and step_phase together: run wins, phase dropped
      v.push_back(mk(5, 1, 3'b011, 0, 0, 3'b000, 3'b000));
      v.push_back(mk(1, 1, 3'b011, 0, 0, 3'b000, 3'b011));
      v.push_back(mk(1, 1, 3'b011, 0, 0, 3'b001, 3'b011));
      v.push_back(mk(4, 1, 3'b011, 0, 0, 3'b000, 3'b011));
      v.push_back(mk(5, 1, 3'b000, 0, 0, 3'b000, 3'b011));
      v.push_back(mk(4, 1, 3'b000, 0, 0, 3'b000, 3'b000));
      // step_phase suppressed while running, issued when stopped
      v.push_back(mk(5, 1, 3'b010, 1, 0, 3'b000, 3'b000));
      v.push_back(mk(1, 1, 3'b010, 1, 0, 3'b000, 3'b010));
      v.push_back(mk(4, 1, 3'b010, 1, 0, 3'b000, 3'b010));
      v.push_back(mk(5, 1, 3'b000, 1, 0, 3'b000, 3'b010));
      v.push_back(mk(4, 1, 3'b000, 1, 0, 3'b000, 3'b000));
      v.push_back(mk(5, 1, 3'b010, 0, 0, 3'b000, 3'b000));
      v.push_back(mk(1, 1, 3'b010, 0, 0, 3'b000, 3'b010));
      v.push_back(mk(1, 1, 3'b010, 0, 0, 3'b010, 3'b010));
      v.push_back(mk(3, 1, 3'b010, 0, 0, 3'b000, 3'b010));
      v.push_back(mk(5, 1, 3'b000, 0, 0, 3'b000, 3'b010));
      v.push_back(mk(4, 1, 3'b000, 0, 0, 3'b000, 3'b000));
      // halt held 20 cycles: one stop; halt while stopped waits for running
      v.push_back(mk(1,  1, 3'b000, 1, 1, 3'b001, 3'b000));
      v.push_back(mk(19, 1, 3'b000, 1, 1, 3'b000, 3'b000));
      v.push_back(mk(3,  1, 3'b000, 0, 0, 3'b000, 3'b000));
      v.push_back(mk(3,  1, 3'b000, 0, 1, 3'b000, 3'b000));
      v.push_back(mk(1,  1, 3'b000, 1, 1, 3'b001, 3'b000));
      v.push_back(mk(4,  1, 3'b000, 1, 1, 3'b000, 3'b000));
      v.push_back(mk(2,  1, 3'b000, 1, 0, 3'b000, 3'b000));
      v.push_back(mk(1,  1, 3'b000, 1, 1, 3'b001, 3'b000));
      v.push_back(mk(3,  1, 3'b000, 1, 1, 3'b000, 3'b000));
      v.push_back(mk(2,  1, 3'b000, 0, 0, 3'b000, 3'b000));
      // run press one cycle into the lockout after a halt stop is dropped
      v.push_back(mk(4, 1, 3'b001, 1, 0, 3'b000, 3'b000));
      v.push_back(mk(1, 1, 3'b001, 1, 1, 3'b001, 3'b000));
      v.push_back(mk(1, 1, 3'b001, 1, 1, 3'b000, 3'b001));
      v.push_back(mk(4, 1, 3'b001, 1, 1, 3'b000, 3'b001));
      v.push_back(mk(5, 1, 3'b000, 1, 0, 3'b000, 3'b001));
      v.push_back(mk(3, 1, 3'b000, 1, 0, 3'b000, 3'b000));
      // run press coincident with halt stop: one pulse
      v.push_back(mk(5, 1, 3'b001, 1, 0, 3'b000, 3'b000));
      v.push_back(mk(1, 1, 3'b001, 1, 0, 3'b000, 3'b001));
      v.push_back(mk(1, 1, 3'b001, 1, 1, 3'b001, 3'b001));
      v.push_back(mk(4, 1, 3'b001, 1, 1, 3'b000, 3'b001));
      v.push_back(mk(5, 1, 3'b000, 1, 0, 3'b000, 3'b001));
      v.push_back(mk(3, 1, 3'b000, 0, 0, 3'b000, 3'b000));
      // run held through reset release; reset in lockout; reset mid-debounce
      v.push_back(mk(3, 0, 3'b001, 0, 0, 3'b000, 3'b000));
      v.push_back(mk(5, 1, 3'b001, 0, 0, 3'b000, 3'b000));
      v.push_back(mk(1, 1, 3'b001, 0, 0, 3'b000, 3'b001));
      v.push_back(mk(1, 1, 3'b001, 0, 0, 3'b001, 3'b001));
      v.push_back(mk(1, 0, 3'b001, 0, 0, 3'b000, 3'b000));
      v.push_back(mk(5, 1, 3'b001, 0, 0, 3'b000, 3'b000));
      v.push_back(mk(1, 1, 3'b001, 0, 0, 3'b000, 3'b001));
      v.push_back(mk(1, 1, 3'b001, 0, 0, 3'b001, 3'b001));
      v.push_back(mk(3, 1, 3'b001, 0, 0, 3'b000, 3'b001));
      v.push_back(mk(5, 1, 3'b000, 0, 0, 3'b000, 3'b001));
      v.push_back(mk(3, 1, 3'b000, 0, 0, 3'b000, 3'b000));
      v.push_back(mk(3, 1, 3'b001, 0, 0, 3'b000, 3'b000));
      v.push_back(mk(1, 0, 3'b001, 0, 0, 3'b000, 3'b000));
      v.push_back(mk(5, 1, 3'b001, 0, 0, 3'b000, 3'b000));
      v.push_back(mk(1, 1, 3'b001, 0, 0, 3'b000, 3'b001));
      v.push_back(mk(1, 1, 3'b001, 0, 0, 3'b001, 3'b001));
      v.push_back(mk(3, 1, 3'b001, 0, 0, 3'b000, 3'b001));
      v.push_back(mk(5, 1, 3'b000, 0, 0, 3'b000, 3'b001));
      v.push_back(mk(3, 1, 3'b000, 0, 0, 3'b000, 3'b000));

      foreach (v[k]) begin
         for (int j = 0; j < v[k].n; j++) begin
            reset = v[k].rst_n;
            {btn_step_inst, btn_step_phase, btn_run} = v[k].btn;
            running = v[k].running;
            halt = v[k].halt;
            @(posedge clock);
            #1;
            applied++;
            if ({step_inst, step_phase, run} !== v[k].req || btn_level !== v[k].lvl) begin
               errors++;
               $display("FAIL vec[%0d] cycle %0d: req=%b lvl=%b, expected req=%b lvl=%b",
                        k, j, {step_inst, step_phase, run}, btn_level, v[k].req, v[k].lvl);
            end
         end
      end

      // hand-written: count pulses across a 20-cycle halt with running high
      pulses = 0; first = -1; others = 0;
      running = 1'b1; halt = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clock);
         #1;
         if (run) begin
            pulses++;
            if (first < 0) first = c;
         end
         if (step_phase || step_inst) others++;
      end
      halt = 1'b0; running = 1'b0;
      applied++;
      if (pulses != 1 || first != 0 || others != 0) begin
         errors++;
         $display("FAIL halt_window: pulses=%0d first=%0d others=%0d, expected pulses=1 first=0 others=0",
                  pulses, first, others);
      end
      repeat (3) @(posedge clock);

      $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
      $finish;
   end
endmodule
